// File: rtl/arb_client_mux_pkg.sv
// Shared defaults and FSM encoding for the arbitrated client mux.
// Also holds a small index-width helper used by the top.
package arb_client_mux_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DW      = 8;
  localparam int DEF_DEPTH   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_client_fifo.sv
// Per-client FIFO: registered storage, combinational head read.
// Push and pop in the same cycle keep the occupancy unchanged and preserve order.
module arb_client_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arb_client_mux.sv
// N client FIFOs multiplexed onto one output through an external round-robin arbiter.
// Optional grant protocol checker enabled by defining ARB_CLIENT_GNT_CHECK_EN.
module arb_client_mux
  import arb_client_mux_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DW      = DEF_DW,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    in_valid,
  input  logic [NUM_REQ*DW-1:0] in_data,
  output logic [NUM_REQ-1:0]    in_ready,
  output logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    gnt,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  input  logic                  out_ready,
  output logic                  gnt_err
);

  localparam int IW = idx_w(NUM_REQ);

  state_t             state;
  state_t             state_nxt;
  logic [NUM_REQ-1:0] full;
  logic [NUM_REQ-1:0] empty;
  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] sel;
  logic [DW-1:0]      fifo_dout [NUM_REQ];
  logic [DW-1:0]      data_q;
  logic [IW-1:0]      pop_idx;
  logic               load;

  assign nonempty  = ~empty;
  assign in_ready  = rst ? '0 : ~full;
  assign push      = in_valid & in_ready;
  assign req       = (!rst && state == ST_ARB) ? nonempty : '0;
  assign sel       = gnt & req;
  assign out_valid = !rst && (state == ST_SEND);
  assign out_data  = rst ? '0 : data_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    arb_client_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .push_data (in_data[g*DW +: DW]),
      .pop       (pop[g]),
      .pop_data  (fifo_dout[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  // Lowest set bit of sel wins, even if the arbiter hands back several grants.
  always_comb begin
    pop_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (sel[i]) pop_idx = IW'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = '0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|nonempty) state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (|sel) begin
          pop[pop_idx] = 1'b1;
          load         = 1'b1;
          state_nxt    = ST_SEND;
        end else if (!(|nonempty)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (out_ready) state_nxt = (|nonempty) ? ST_ARB : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (load) data_q <= fifo_dout[pop_idx];
    end
  end

`ifdef ARB_CLIENT_GNT_CHECK_EN
  logic gnt_err_q;
  logic gnt_bad;

  assign gnt_bad = ((gnt & (gnt - NUM_REQ'(1))) != '0) || ((gnt & ~req) != '0);
  assign gnt_err = gnt_err_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_err_q <= 1'b0;
    end else if (state == ST_ARB && gnt_bad) begin
      gnt_err_q <= 1'b1;
    end
  end
`else
  assign gnt_err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_client_mux.sv
// Bench for arb_client_mux: behavioural round-robin arbiter, queue-based model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_arb_client_mux;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PH_IDLE = 0;
  localparam int PH_ARB  = 1;
  localparam int PH_SEND = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic            gnt_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arb_client_mux #(.NUM_REQ(N), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req       (req),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .gnt_err   (gnt_err)
  );

  // Round-robin arbiter: search starts one past the last winner.
  int           rr_last = N - 1;
  logic [N-1:0] rr_gnt;
  logic         force_en;
  logic [N-1:0] force_val;

  always_comb begin
    rr_gnt = '0;
    for (int k = 1; k <= N; k++) begin
      if (rr_gnt == '0 && req[(rr_last + k) % N]) rr_gnt[(rr_last + k) % N] = 1'b1;
    end
  end

  assign gnt = force_en ? force_val : rr_gnt;

  always @(posedge clk) begin
    if (rst) rr_last <= N - 1;
    else if (req != '0) begin
      for (int k = 0; k < N; k++) if (rr_gnt[k]) rr_last <= k;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Model state: per-client queues, phase, held output beat, sticky error.
  logic [DW-1:0] mq [N][$];
  int            m_phase = PH_IDLE;
  logic [DW-1:0] m_data  = '0;
  logic          m_gerr  = 1'b0;

  typedef struct {
    int            c;
    logic [DW-1:0] d;
  } beat_t;
  beat_t beats[$];

  logic [N-1:0]  e_rdy, e_req, e_sel, can_push;
  logic          e_vld, e_gerr, any_ne;
  logic [DW-1:0] e_dat;
  int            win;

  always @(negedge clk) begin
    any_ne = 1'b0;
    for (int i = 0; i < N; i++) if (mq[i].size() != 0) any_ne = 1'b1;
    if (rst) begin
      e_rdy = '0; e_req = '0; e_vld = 1'b0; e_dat = '0; e_gerr = 1'b0;
    end else begin
      e_req = '0;
      for (int i = 0; i < N; i++) begin
        e_rdy[i] = (mq[i].size() < DEPTH);
        if (m_phase == PH_ARB) e_req[i] = (mq[i].size() != 0);
      end
      e_vld  = (m_phase == PH_SEND);
      e_dat  = m_data;
      e_gerr = m_gerr;
    end
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("req", 32'(req), 32'(e_req));
    chk("out_valid", 32'(out_valid), 32'(e_vld));
    chk("gnt_err", 32'(gnt_err), 32'(e_gerr));
    if (e_vld || rst) chk("out_data", 32'(out_data), 32'(e_dat));
    if (!rst && out_valid && out_ready) beats.push_back('{cyc, out_data});

    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_phase = PH_IDLE; m_data = '0; m_gerr = 1'b0;
    end else begin
      can_push = e_rdy & in_valid;
      case (m_phase)
        PH_IDLE: if (any_ne) m_phase = PH_ARB;
        PH_ARB: begin
`ifdef ARB_CLIENT_GNT_CHECK_EN
          if ($countones(gnt) > 1 || (gnt & ~e_req) != '0) m_gerr = 1'b1;
`endif
          e_sel = gnt & e_req;
          win = -1;
          for (int i = N - 1; i >= 0; i--) if (e_sel[i]) win = i;
          if (win >= 0) begin
            m_data  = mq[win].pop_front();
            m_phase = PH_SEND;
          end else if (!any_ne) begin
            m_phase = PH_IDLE;
          end
        end
        default: if (out_ready) m_phase = any_ne ? PH_ARB : PH_IDLE;
      endcase
      for (int i = 0; i < N; i++) if (can_push[i]) mq[i].push_back(in_data[i*DW +: DW]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    beats.delete();
  endtask

  task automatic wait_beats(input string name, input int n, input int budget);
    int c = 0;
    while (beats.size() < n && c < budget) begin
      samp();
      c++;
    end
    chk(name, 32'(beats.size()), 32'(n));
  endtask

  task automatic wait_valid();
    int c = 0;
    samp();
    while (!out_valid && c < 20) begin
      step(1);
      samp();
      c++;
    end
    chk("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  int t0;

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
    force_en = 1'b0; force_val = '0;

    // Reset values, then in_ready opens the cycle after release.
    step(1);
    samp();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    step(1);
    rst = 1'b0;
    samp();
    chk("post_rst_in_ready", 32'(in_ready), 32'hF);

    // Single beat on client 2: req in ARB at t+2, beat at t+3.
    do_reset();
    in_valid = 4'b0100; in_data = '0; in_data[2*DW +: DW] = 8'h11;
    t0 = cyc;
    step(1);
    in_valid = '0;
    step(1);
    samp();
    chk("t1_req", 32'(req), 32'b0100);
    wait_beats("t1_count", 1, 20);
    if (beats.size() >= 1) begin
      chk("t1_data", 32'(beats[0].d), 32'h11);
      chk("t1_latency", 32'(beats[0].c - t0), 32'd3);
    end
    step(10);
    chk("t1_single", 32'(beats.size()), 32'd1);

    // All four clients at once: in index order, two cycles apart.
    do_reset();
    in_valid = 4'b1111; in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    t0 = cyc;
    step(1);
    in_valid = '0;
    wait_beats("t2_count", 4, 40);
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      chk("t2_data", 32'(beats[i].d), 32'hA0 + 32'(i));
      chk("t2_time", 32'(beats[i].c - t0), 32'(3 + 2 * i));
    end

    // Fill client 1 with grants withheld; extra push dropped; drain four.
    do_reset();
    force_en = 1'b1; force_val = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 4'b0010; in_data = '0; in_data[DW +: DW] = 8'hB0 + 8'(i);
      step(1);
    end
    in_valid = '0;
    samp();
    chk("t3_in_ready", 32'(in_ready), 32'b1101);
    step(1);
    in_valid = 4'b0010; in_data = '0; in_data[DW +: DW] = 8'hFF;
    step(1);
    in_valid = '0; force_en = 1'b0;
    wait_beats("t3_count", 4, 60);
    for (int i = 0; i < 4 && i < beats.size(); i++) chk("t3_data", 32'(beats[i].d), 32'hB0 + 32'(i));
    step(20);
    chk("t3_no_extra", 32'(beats.size()), 32'd4);

    // Stall in SEND for five cycles, then release one beat.
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b1000; in_data = '0; in_data[3*DW +: DW] = 8'h5C;
    step(1);
    in_valid = '0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) samp();
      chk("t4_valid", 32'(out_valid), 32'd1);
      chk("t4_data", 32'(out_data), 32'h5C);
      chk("t4_req", 32'(req), 32'd0);
      step(1);
    end
    out_ready = 1'b1;
    step(10);
    chk("t4_count", 32'(beats.size()), 32'd1);
    if (beats.size() >= 1) chk("t4_beat", 32'(beats[0].d), 32'h5C);

    // Illegal two-hot grant: lowest index popped; sticky error only with the checker.
    do_reset();
    in_valid = 4'b0011; in_data = '0; in_data[0 +: DW] = 8'hC0; in_data[DW +: DW] = 8'hC1;
    step(1);
    in_valid = '0;
    step(1);
    force_en = 1'b1; force_val = 4'b0011;
    step(1);
    force_en = 1'b0;
    samp();
`ifdef ARB_CLIENT_GNT_CHECK_EN
    chk("t5_gnt_err_set", 32'(gnt_err), 32'd1);
`else
    chk("t5_gnt_err_tied", 32'(gnt_err), 32'd0);
`endif
    wait_beats("t5_count", 2, 40);
    if (beats.size() >= 2) begin
      chk("t5_first", 32'(beats[0].d), 32'hC0);
      chk("t5_second", 32'(beats[1].d), 32'hC1);
    end
    step(5);
    samp();
`ifdef ARB_CLIENT_GNT_CHECK_EN
    chk("t5_gnt_err_sticky", 32'(gnt_err), 32'd1);
`else
    chk("t5_gnt_err_still0", 32'(gnt_err), 32'd0);
`endif
    do_reset();
    samp();
    chk("t5_gnt_err_cleared", 32'(gnt_err), 32'd0);

    // Reset in the middle of SEND drops the pending beat.
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b0001; in_data = '0; in_data[0 +: DW] = 8'h77;
    step(1);
    in_valid = '0;
    wait_valid();
    step(1);
    rst = 1'b1;
    step(2);
    rst = 1'b0; out_ready = 1'b1;
    step(15);
    chk("t6_dropped", 32'(beats.size()), 32'd0);
    samp();
    chk("t6_idle_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/arb_client_mux.md
ARB_CLIENT_MUX -- requirements
Module: arb_client_mux

Interface
REQ-001 Parameter NUM_REQ, default 4, number of client ports; also req/gnt width.
REQ-002 Parameter DW, default 8, data width per beat.
REQ-003 Parameter DEPTH, default 4, entries per client FIFO (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  NUM_REQ  per-client push strobe.
REQ-007 in_data  input  NUM_REQ*DW  client i data in bits [i*DW +: DW].
REQ-008 in_ready  output  NUM_REQ  per-client FIFO not full.
REQ-009 req  output  NUM_REQ  request vector to the round-robin arbiter.
REQ-010 gnt  input  NUM_REQ  one-hot grant, combinational function of req from the arbiter.
REQ-011 out_valid  output  1  shared output beat valid.
REQ-012 out_data  output  DW  shared output data.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 gnt_err  output  1  sticky grant protocol error flag.

Function
REQ-015 Per-client FIFO i shall push when in_valid[i] && in_ready[i]; in_ready[i] = !full[i], independent of a same-cycle pop.
REQ-016 FSM states IDLE, ARB, SEND; state register encoded in three or fewer bits.
REQ-017 IDLE: req = 0; go to ARB next cycle when any FIFO non-empty.
REQ-018 ARB: req[i] = !empty[i]; sel = gnt & req; if sel != 0, pop the lowest-index set bit of sel, load out_data, go to SEND; if sel == 0, stay in ARB (back to IDLE if all empty).
REQ-019 SEND: req = 0, out_valid = 1, out_data stable; on out_ready go to ARB if any FIFO non-empty, else IDLE.
REQ-020 Latency: empty-system push at cycle t gives out_valid at cycle t+3 (FIFO write, IDLE->ARB, pop/load).
REQ-021 Throughput: at most one beat every two cycles (ARB, SEND alternate); req held 0 in SEND so arbiter history does not advance.
REQ-022 gnt bits outside req shall be ignored; gnt arriving outside ARB shall be ignored.
REQ-023 FIFO pointers shall wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-024 Push and pop on the same FIFO in the same cycle shall leave occupancy unchanged and preserve order.

Reset
REQ-025 While rst high: FIFOs empty, state IDLE, req = 0, out_valid = 0, out_data = 0, gnt_err = 0, in_ready = 0.
REQ-026 First cycle after rst low: in_ready = all ones.
REQ-027 Reset mid-SEND shall drop the pending beat; no beat emitted after reset without a fresh push.

Configuration
REQ-028 Macro ARB_CLIENT_GNT_CHECK_EN: when defined, gnt_err shall set (sticky until rst) in ARB if gnt is not one-hot-or-zero, or gnt & ~req != 0.
REQ-029 Without ARB_CLIENT_GNT_CHECK_EN: gnt_err tied 0, no check logic; REQ-018 lowest-index rule still applies.

Structure
REQ-030 Shared package holds the FSM state encoding constants and the default NUM_REQ/DW/DEPTH values.
REQ-031 One sub-module, arb_client_fifo (DW, DEPTH), instantiated NUM_REQ times by generate loop.

Verification
REQ-032 Bench shall pair the DUT with a behavioural round-robin arbiter (one-hot grant, history rotates on any req).
REQ-033 Push 0x11 to client 2 only, out_ready=1 -> req=4'b0100 in ARB, out_data=0x11 valid at t+3, one beat.
REQ-034 Push 0xA0..0xA3 to clients 0..3 same cycle, out_ready=1 -> out_data order 0xA0,0xA1,0xA2,0xA3, beats 2 cycles apart.
REQ-035 Fill client 1 with DEPTH=4 beats -> in_ready[1]=0; extra push dropped; drain yields exactly 4 beats in order.
REQ-036 Hold out_ready=0 for 5 cycles in SEND -> out_valid=1, out_data stable, req=0 throughout; release -> one beat.
REQ-037 With ARB_CLIENT_GNT_CHECK_EN, force gnt=4'b0011 in ARB -> gnt_err=1 next cycle, remains 1 until rst; client 0 popped.
